// File: rtl/irq_ctrl.sv
// irq_ctrl: four-line edge-triggered interrupt controller with enable mask,
// fixed lowest-index-first priority and a committed single-grant handshake.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no grant outstanding; waiting for an eligible interrupt
//   REQ     | int_req high; int_id/int_vec frozen until CPU acknowledges
//   SERVICE | handler running; new edges only accumulate in pending
module irq_ctrl #(
  parameter int unsigned         PC_W     = 10,
  parameter logic [PC_W-1:0]     VEC_BASE = 10'h3F0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      irq,
  input  logic            ie_we,
  input  logic [3:0]      ie_wdata,
  input  logic            int_ack,
  input  logic            reti,
  output logic            int_req,
  output logic [PC_W-1:0] int_vec,
  output logic [1:0]      int_id,
  output logic            in_service,
  output logic [3:0]      pending,
  output logic [3:0]      ie
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      irq_q;
  logic [3:0]      pending_q, pending_d;
  logic [3:0]      ie_q, ie_d;
  logic [1:0]      id_q, id_d;
  logic [PC_W-1:0] vec_q, vec_d;

  logic [3:0]      irq_rise;
  logic [3:0]      eligible;
  logic [1:0]      win_id;

  assign irq_rise = irq & ~irq_q;
  assign eligible = pending_q & ie_q;

  // Fixed priority: lowest set index of the eligible vector wins.
  always_comb begin
    win_id = 2'd0;
    casez (eligible)
      4'b???1: win_id = 2'd0;
      4'b??10: win_id = 2'd1;
      4'b?100: win_id = 2'd2;
      4'b1000: win_id = 2'd3;
      default: win_id = 2'd0;
    endcase
  end

  // Next state, grant latch, pending and mask update.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    vec_d     = vec_q;
    pending_d = pending_q;
    ie_d      = ie_q;

    if (ie_we) begin
      ie_d = ie_wdata;
    end

    case (state_q)
      IDLE: begin
        if (eligible != 4'b0000) begin
          state_d = REQ;
          id_d    = win_id;
          // Wraps modulo 2^PC_W by construction of the sum width.
          vec_d   = VEC_BASE + PC_W'({win_id, 2'b00});
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d         = SERVICE;
          pending_d[id_q] = 1'b0;
        end
      end
      SERVICE: begin
        if (reti) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new edge in the acknowledge cycle must not be lost: set wins.
    pending_d = pending_d | irq_rise;
  end

  // State and datapath registers; irq_q keeps tracking irq during reset so a
  // line held high across release is not seen as a fresh edge.
  always_ff @(posedge clk) begin
    irq_q <= irq;
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      ie_q      <= 4'b0000;
      id_q      <= 2'd0;
      vec_q     <= VEC_BASE;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ie_q      <= ie_d;
      id_q      <= id_d;
      vec_q     <= vec_d;
    end
  end

  assign int_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign int_id     = id_q;
  assign int_vec    = vec_q;
  assign pending    = pending_q;
  assign ie         = ie_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Inputs change 1ns after a rising edge and
// outputs are sampled at the same point, away from the active edge.
module tb_irq_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       ie_we;
  logic [3:0] ie_wdata;
  logic       int_ack;
  logic       reti;
  logic       int_req;
  logic [9:0] int_vec;
  logic [1:0] int_id;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] ie;

  int checks;
  int passed;

  irq_ctrl #(.PC_W(10), .VEC_BASE(10'h3F0)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .ie_we      (ie_we),
    .ie_wdata   (ie_wdata),
    .int_ack    (int_ack),
    .reti       (reti),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .in_service (in_service),
    .pending    (pending),
    .ie         (ie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ie(input logic [3:0] m);
    ie_we = 1'b1; ie_wdata = m;
    step(1);
    ie_we = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (int_req !== 1'b0) $display("FAIL rst_int_req got %b exp 0", int_req); else passed++;
    checks++; if (in_service !== 1'b0) $display("FAIL rst_in_service got %b exp 0", in_service); else passed++;
    checks++; if (pending !== 4'b0000) $display("FAIL rst_pending got %b exp 0000", pending); else passed++;
    checks++; if (ie !== 4'b0000) $display("FAIL rst_ie got %b exp 0000", ie); else passed++;
    checks++; if (int_id !== 2'd0) $display("FAIL rst_int_id got %0d exp 0", int_id); else passed++;
    checks++; if (int_vec !== 10'h3F0) $display("FAIL rst_int_vec got %h exp 3f0", int_vec); else passed++;
  endtask

  task automatic test_single;
    set_ie(4'b1111);
    checks++; if (ie !== 4'b1111) $display("FAIL single_ie got %b exp 1111", ie); else passed++;
    irq = 4'b0100;
    step(1);
    checks++; if (pending !== 4'b0100) $display("FAIL single_pending got %b exp 0100", pending); else passed++;
    checks++; if (int_req !== 1'b0) $display("FAIL single_req_early got %b exp 0", int_req); else passed++;
    irq = 4'b0000;
    step(1);
    checks++; if (int_req !== 1'b1) $display("FAIL single_req got %b exp 1", int_req); else passed++;
    checks++; if (int_id !== 2'd2) $display("FAIL single_id got %0d exp 2", int_id); else passed++;
    checks++; if (int_vec !== 10'h3F8) $display("FAIL single_vec got %h exp 3f8", int_vec); else passed++;
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    checks++; if (int_req !== 1'b0) $display("FAIL single_req_after_ack got %b exp 0", int_req); else passed++;
    checks++; if (in_service !== 1'b1) $display("FAIL single_in_service got %b exp 1", in_service); else passed++;
    checks++; if (pending !== 4'b0000) $display("FAIL single_pending_clr got %b exp 0000", pending); else passed++;
    step(1);
    checks++; if (in_service !== 1'b1) $display("FAIL single_in_service_hold got %b exp 1", in_service); else passed++;
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    checks++; if (in_service !== 1'b0) $display("FAIL single_reti got %b exp 0", in_service); else passed++;
    checks++; if (int_req !== 1'b0) $display("FAIL single_idle_req got %b exp 0", int_req); else passed++;
  endtask

  task automatic test_priority;
    irq = 4'b1010;
    step(1);
    irq = 4'b0000;
    checks++; if (pending !== 4'b1010) $display("FAIL prio_pending got %b exp 1010", pending); else passed++;
    step(1);
    checks++; if (int_id !== 2'd1) $display("FAIL prio_id1 got %0d exp 1", int_id); else passed++;
    checks++; if (int_vec !== 10'h3F4) $display("FAIL prio_vec1 got %h exp 3f4", int_vec); else passed++;
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    checks++; if (pending !== 4'b1000) $display("FAIL prio_pending_after_ack got %b exp 1000", pending); else passed++;
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    checks++; if (int_req !== 1'b0 || in_service !== 1'b0)
      $display("FAIL prio_idle_gap got req=%b svc=%b exp 0/0", int_req, in_service); else passed++;
    step(1);
    checks++; if (int_req !== 1'b1) $display("FAIL prio_req3 got %b exp 1", int_req); else passed++;
    checks++; if (int_id !== 2'd3) $display("FAIL prio_id3 got %0d exp 3", int_id); else passed++;
    checks++; if (int_vec !== 10'h3FC) $display("FAIL prio_vec3 got %h exp 3fc", int_vec); else passed++;
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    reti = 1'b1; step(1); reti = 1'b0;
  endtask

  task automatic test_mask;
    set_ie(4'b0000);
    irq = 4'b0001;
    step(1);
    irq = 4'b0000;
    checks++; if (pending !== 4'b0001) $display("FAIL mask_pending got %b exp 0001", pending); else passed++;
    step(2);
    checks++; if (int_req !== 1'b0) $display("FAIL mask_no_req got %b exp 0", int_req); else passed++;
    set_ie(4'b0001);
    checks++; if (int_req !== 1'b0) $display("FAIL mask_req_early got %b exp 0", int_req); else passed++;
    step(1);
    checks++; if (int_req !== 1'b1) $display("FAIL mask_req got %b exp 1", int_req); else passed++;
    checks++; if (int_id !== 2'd0) $display("FAIL mask_id got %0d exp 0", int_id); else passed++;
    // Masking during REQ neither withdraws the grant nor clears pending.
    set_ie(4'b0000);
    checks++; if (int_req !== 1'b1 || int_id !== 2'd0)
      $display("FAIL mask_committed got req=%b id=%0d exp 1/0", int_req, int_id); else passed++;
    checks++; if (pending !== 4'b0001) $display("FAIL mask_keeps_pending got %b exp 0001", pending); else passed++;
    set_ie(4'b1111);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    checks++; if (pending !== 4'b0000) $display("FAIL mask_ack_clr got %b exp 0000", pending); else passed++;
    reti = 1'b1; step(1); reti = 1'b0;
  endtask

  task automatic test_preempt;
    irq = 4'b0100; step(1); irq = 4'b0000;
    step(1);
    checks++; if (int_id !== 2'd2) $display("FAIL pre_id2 got %0d exp 2", int_id); else passed++;
    irq = 4'b0001; step(1); irq = 4'b0000;
    checks++; if (int_id !== 2'd2) $display("FAIL pre_id_hold got %0d exp 2", int_id); else passed++;
    checks++; if (int_vec !== 10'h3F8) $display("FAIL pre_vec_hold got %h exp 3f8", int_vec); else passed++;
    checks++; if (pending !== 4'b0101) $display("FAIL pre_pending got %b exp 0101", pending); else passed++;
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    checks++; if (pending !== 4'b0001) $display("FAIL pre_pending_ack got %b exp 0001", pending); else passed++;
    checks++; if (in_service !== 1'b1) $display("FAIL pre_svc got %b exp 1", in_service); else passed++;
    reti = 1'b1; step(1); reti = 1'b0;
    step(1);
    checks++; if (int_req !== 1'b1 || int_id !== 2'd0)
      $display("FAIL pre_id0 got req=%b id=%0d exp 1/0", int_req, int_id); else passed++;
    checks++; if (int_vec !== 10'h3F0) $display("FAIL pre_vec0 got %h exp 3f0", int_vec); else passed++;
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    reti = 1'b1; step(1); reti = 1'b0;
  endtask

  task automatic test_back_to_back;
    irq = 4'b0010; step(1); irq = 4'b0000;
    step(1);
    checks++; if (int_id !== 2'd1) $display("FAIL b2b_id got %0d exp 1", int_id); else passed++;
    irq = 4'b0010; int_ack = 1'b1;
    step(1);
    irq = 4'b0000; int_ack = 1'b0;
    checks++; if (pending !== 4'b0010) $display("FAIL b2b_set_wins got %b exp 0010", pending); else passed++;
    checks++; if (in_service !== 1'b1) $display("FAIL b2b_svc got %b exp 1", in_service); else passed++;
    reti = 1'b1; step(1); reti = 1'b0;
    checks++; if (int_req !== 1'b0) $display("FAIL b2b_gap got %b exp 0", int_req); else passed++;
    step(1);
    checks++; if (int_req !== 1'b1 || int_id !== 2'd1)
      $display("FAIL b2b_reserve got req=%b id=%0d exp 1/1", int_req, int_id); else passed++;
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    checks++; if (pending !== 4'b0000) $display("FAIL b2b_clr got %b exp 0000", pending); else passed++;
    reti = 1'b1; step(1); reti = 1'b0;
  endtask

  task automatic test_protocol;
    reti = 1'b1; step(1); reti = 1'b0;
    checks++; if (int_req !== 1'b0 || in_service !== 1'b0)
      $display("FAIL proto_reti_idle got req=%b svc=%b exp 0/0", int_req, in_service); else passed++;
    set_ie(4'b0000);
    irq = 4'b1000; step(1); irq = 4'b0000;
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    checks++; if (pending !== 4'b1000) $display("FAIL proto_ack_idle_pending got %b exp 1000", pending); else passed++;
    checks++; if (in_service !== 1'b0) $display("FAIL proto_ack_idle_svc got %b exp 0", in_service); else passed++;
    set_ie(4'b1111);
    step(1);
    checks++; if (int_req !== 1'b1 || int_id !== 2'd3)
      $display("FAIL proto_req got req=%b id=%0d exp 1/3", int_req, int_id); else passed++;
    reti = 1'b1; step(1); reti = 1'b0;
    checks++; if (int_req !== 1'b1) $display("FAIL proto_reti_in_req got %b exp 1", int_req); else passed++;
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    checks++; if (in_service !== 1'b1) $display("FAIL proto_ack_in_svc got %b exp 1", in_service); else passed++;
    reti = 1'b1; step(1); reti = 1'b0;
  endtask

  task automatic test_reset_cases;
    irq = 4'b0010; reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    checks++; if (pending !== 4'b0000) $display("FAIL rsthold_pending got %b exp 0000", pending); else passed++;
    step(1);
    checks++; if (int_req !== 1'b0) $display("FAIL rsthold_req got %b exp 0", int_req); else passed++;
    irq = 4'b0000;
    set_ie(4'b1111);
    irq = 4'b0100; step(1); irq = 4'b0000;
    step(1);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    irq = 4'b0001; step(1); irq = 4'b0000;
    checks++; if (in_service !== 1'b1 || pending !== 4'b0001)
      $display("FAIL rstsvc_pre got svc=%b pend=%b exp 1/0001", in_service, pending); else passed++;
    reset = 1'b1; int_ack = 1'b1; step(1); reset = 1'b0; int_ack = 1'b0;
    checks++; if (in_service !== 1'b0) $display("FAIL rstsvc_svc got %b exp 0", in_service); else passed++;
    checks++; if (pending !== 4'b0000) $display("FAIL rstsvc_pending got %b exp 0000", pending); else passed++;
    checks++; if (ie !== 4'b0000 || int_id !== 2'd0 || int_vec !== 10'h3F0)
      $display("FAIL rstsvc_regs got ie=%b id=%0d vec=%h exp 0000/0/3f0", ie, int_id, int_vec); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    reset = 1'b1; irq = 4'b0000; ie_we = 1'b0; ie_wdata = 4'b0000;
    int_ack = 1'b0; reti = 1'b0;
    step(2);
    reset = 1'b0;
    test_reset;
    test_single;
    test_priority;
    test_mask;
    test_preempt;
    test_back_to_back;
    test_protocol;
    test_reset_cases;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: VEC_BASE, 10'h3F0, vector of interrupt 0; interrupt n vector = VEC_BASE + 4*n.
REQ-002 Parameter: PC_W, 10, width of int_vec.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq  input  4  interrupt lines, already synchronous to clk; a rising edge requests service.
REQ-006 ie_we  input  1  write strobe for the enable mask.
REQ-007 ie_wdata  input  4  new enable mask; bit n enables irq[n].
REQ-008 int_ack  input  1  CPU has pushed return PC and jumped to int_vec.
REQ-009 reti  input  1  CPU executed return-from-interrupt.
REQ-010 int_req  output  1  interrupt request to CPU.
REQ-011 int_vec  output  PC_W  vector address of the granted interrupt.
REQ-012 int_id  output  2  index of the granted interrupt.
REQ-013 in_service  output  1  handler currently executing.
REQ-014 pending  output  4  latched, not-yet-acknowledged edges.
REQ-015 ie  output  4  current enable mask.

Function
REQ-016 Edge detect: irq_q registers irq each cycle; edge[n] = irq[n] & ~irq_q[n].
REQ-017 Pending set: edge[n] sets pending[n] on the same clock edge, regardless of ie[n].
REQ-018 Pending clear: pending[int_id] clears on the clock edge where the FSM is in REQ and int_ack = 1. If edge[int_id] occurs in that same cycle, set wins and pending stays 1.
REQ-019 Mask: ie_we = 1 loads ie <= ie_wdata in any state. Masking never clears pending bits.
REQ-020 Eligible = pending & ie. Fixed priority: lowest index wins (irq[0] highest).
REQ-021 FSM has three states: IDLE, REQ, SERVICE.
REQ-022 IDLE -> REQ when Eligible != 0. In the same edge, int_id and int_vec latch the winner.
REQ-023 REQ: int_req = 1. int_id and int_vec hold stable until exit, even if the mask or pending bits change or a higher-priority interrupt arrives; the grant is committed.
REQ-024 REQ -> SERVICE on int_ack = 1; int_req deasserts the following cycle.
REQ-025 SERVICE: in_service = 1, int_req = 0. No nesting; new edges only accumulate in pending.
REQ-026 SERVICE -> IDLE on reti = 1. If Eligible != 0 afterwards, REQ is re-entered one cycle later, so at least one IDLE cycle separates handlers.
REQ-027 Protocol violations: reti outside SERVICE and int_ack outside REQ are ignored with no state change.
REQ-028 Outputs are registered; int_req and in_service are decoded from the state register only.
REQ-029 Latency: irq rises before edge k, so pending is set at edge k, REQ is entered at edge k+1, and int_req is high in the cycle after edge k+1. Latency is 2 clocks from edge to request.
REQ-030 int_vec = VEC_BASE + {int_id, 2'b00}, computed modulo 2^PC_W; wrap-around is permitted and not flagged.

Reset
REQ-031 Reset = 1 at a clock edge forces: state IDLE, pending = 0, ie = 0, int_id = 0, int_vec = VEC_BASE, int_req = 0, in_service = 0.
REQ-032 During reset, irq_q <= irq, so a line held high through reset generates no edge after release.
REQ-033 Reset overrides all other inputs in the same cycle, including mid-REQ and mid-SERVICE.

Verification
REQ-034 ie = 4'b1111; pulse irq[2] -> pending = 4'b0100; int_req high 2 cycles after the edge; int_vec = 10'h3F8; int_id = 2.
REQ-035 ie = 4'b1111; irq[3] and irq[1] rise together -> grant id 1, vec 10'h3F4; after int_ack and reti, one IDLE cycle, then grant id 3, vec 10'h3FC.
REQ-036 ie = 4'b0000; pulse irq[0] -> pending = 4'b0001, int_req stays 0; then write ie = 4'b0001 -> int_req rises 1 cycle later with id 0.
REQ-037 In REQ for id 2, irq[0] rises -> int_id remains 2 until int_ack; id 0 is served after reti.
REQ-038 irq[1] held high across reset release -> pending stays 0. Asserting reset while in SERVICE -> next cycle in_service = 0 and pending = 0.
REQ-039 Edge on irq[int_id] in the int_ack cycle -> pending[int_id] remains 1; served again after reti.
